// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; optional parity bit via UART_PARITY_EN.
// Latency: first START bit on the edge after the pop; wr_ready drops only when the registered level is full.
module uart_tx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [31:0]              div,
    input  logic                     stop2,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     tx,
    output logic                     busy,
    output logic                     done,
`ifdef UART_PARITY_EN
    input  logic                     parity_odd,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_W-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;

    state_t            r_state;
    logic [31:0]       r_cnt;
    logic [31:0]       r_div;
    logic              r_stop2;
    logic              r_stop_idx;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_bitcnt;
    logic              r_tx;
`ifdef UART_PARITY_EN
    logic              r_par;
`endif

    logic              w_push;
    logic              w_pop;
    logic              w_bit_end;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shifted;

    assign w_push      = wr_valid && wr_ready;
    assign w_bit_end   = (r_cnt == 32'd0);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (!r_stop2 || r_stop_idx);
    // A pop happens either from IDLE or exactly at the end of a frame, so frames chain without an idle bit.
    assign w_pop       = enable && (r_level != '0) && ((r_state == S_IDLE) || w_frame_end);
    assign w_rd_data   = r_mem[r_rptr];
    assign w_next_bit  = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];
    assign w_shifted   = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                          : {1'b0, r_shift[DATA_W-1:1]};

    assign wr_ready = (r_level != FULL);
    assign level    = r_level;
    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE);
    // Gated by enable so a frozen last stop cycle cannot stretch the pulse.
    assign done     = enable && w_frame_end;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else if (enable) begin
            if (w_pop) begin
                r_state    <= S_START;
                r_shift    <= w_rd_data;
                r_div      <= div;
                r_cnt      <= div;
                r_stop2    <= stop2;
                r_stop_idx <= 1'b0;
                r_bitcnt   <= '0;
                r_tx       <= 1'b0;
`ifdef UART_PARITY_EN
                r_par      <= (^w_rd_data) ^ parity_odd;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_state <= S_DATA;
                            r_tx    <= w_next_bit;
                            r_shift <= w_shifted;
                            r_cnt   <= r_div;
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_cnt <= r_div;
                            if (r_bitcnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
`else
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
`endif
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                                r_tx     <= w_next_bit;
                                r_shift  <= w_shifted;
                            end
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                            r_cnt   <= r_div;
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_bit_end) begin
                            if (r_stop2 && !r_stop_idx) begin
                                r_stop_idx <= 1'b1;
                                r_cnt      <= r_div;
                            end else begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: MSB-first default instance plus an LSB-first instance.
module tb_uart_tx_fifo;

`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L1 = 10 + P;

    logic        clk = 1'b0;
    logic        rstn;
    logic        parity_odd;

    logic        enable, stop2, wr_valid, wr_ready, tx, busy, done;
    logic [31:0] div;
    logic [7:0]  wr_data;
    logic [2:0]  level;

    logic        b_enable, b_stop2, b_wr_valid, b_wr_ready, b_tx, b_busy, b_done;
    logic [31:0] b_div;
    logic [7:0]  b_wr_data;
    logic [2:0]  b_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .div(div), .stop2(stop2),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .tx(tx), .busy(busy), .done(done),
`ifdef UART_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .level(level)
    );

    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rstn(rstn), .enable(b_enable), .div(b_div), .stop2(b_stop2),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .tx(b_tx), .busy(b_busy), .done(b_done),
`ifdef UART_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .level(b_level)
    );

    // Expected line level for bit slot idx of a frame (0 = start); parity_odd is held at 0.
    function automatic logic exp_bit(input logic [7:0] d, input int idx, input bit msb);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return msb ? d[8-idx] : d[idx-1];
        if (P == 1 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset;
        rstn = 1'b0; parity_odd = 1'b0;
        enable = 1'b0; div = 32'd0; stop2 = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        b_enable = 1'b0; b_div = 32'd0; b_stop2 = 1'b0; b_wr_valid = 1'b0; b_wr_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int tab [L1];
        int flen;
`ifdef UART_PARITY_EN
        tab = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        tab = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
        flen = L1 * 4;
        enable = 1'b1; div = 32'd3; stop2 = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL basic_level_push got=%0d exp=1", level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_pre got=%b exp=0", busy); end
        for (int c = 1; c <= flen; c++) begin
            @(negedge clk);
            checks++; if (tx !== tab[(c-1)/4][0]) begin failures++; $display("FAIL basic_tx c=%0d got=%b exp=%0d", c, tx, tab[(c-1)/4]); end
            checks++; if (done !== (c == flen)) begin failures++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, c == flen); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy c=%0d got=%b exp=1", c, busy); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1 || level !== 3'd0) begin
            failures++; $display("FAIL basic_idle busy=%b tx=%b level=%0d exp 0/1/0", busy, tx, level);
        end
    endtask

    task automatic test_stop2_latch;
        int flen;
        flen = (L1 + 1) * 4;
        div = 32'd3; stop2 = 1'b1;
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int c = 1; c <= flen; c++) begin
            @(negedge clk);
            checks++; if (tx !== exp_bit(8'hA5, (c-1)/4, 1'b1)) begin failures++; $display("FAIL stop2_tx c=%0d got=%b exp=%b", c, tx, exp_bit(8'hA5, (c-1)/4, 1'b1)); end
            checks++; if (done !== (c == flen)) begin failures++; $display("FAIL stop2_done c=%0d got=%b exp=%b", c, done, c == flen); end
            if (c == 2) begin
                div = 32'd0; stop2 = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop2_end_busy got=%b exp=0", busy); end
        div = 32'd3;
    endtask

    task automatic test_full_backpressure;
        logic [7:0] w [5];
        w = '{8'h0F, 8'h33, 8'h55, 8'hC3, 8'h99};
        enable = 1'b0; div = 32'd0; stop2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = w[i];
            checks++; if (wr_ready !== (i < 4)) begin failures++; $display("FAIL full_wr_ready i=%0d got=%b exp=%b", i, wr_ready, i < 4); end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL full_frozen tx=%b busy=%b exp 1/0", tx, busy); end
        enable = 1'b1; wr_valid = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL full_push_pop level got=%0d exp=3", level); end
        for (int k = 0; k < 4 * L1; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (tx !== exp_bit(w[k/L1], k % L1, 1'b1)) begin failures++; $display("FAIL drain_tx k=%0d got=%b exp=%b", k, tx, exp_bit(w[k/L1], k % L1, 1'b1)); end
            checks++; if (done !== ((k % L1) == L1 - 1)) begin failures++; $display("FAIL drain_done k=%0d got=%b", k, done); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drain_busy k=%0d got=%b exp=1", k, busy); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || level !== 3'd0 || tx !== 1'b1) begin
            failures++; $display("FAIL drain_end busy=%b level=%0d tx=%b exp 0/0/1", busy, level, tx);
        end
    endtask

    task automatic test_lsb_back_to_back;
        logic [7:0] d;
        b_enable = 1'b1; b_div = 32'd0; b_stop2 = 1'b0;
        b_wr_valid = 1'b1; b_wr_data = 8'h01;
        @(negedge clk);
        b_wr_data = 8'h80;
        @(negedge clk);
        b_wr_valid = 1'b0;
        checks++; if (b_level !== 3'd1) begin failures++; $display("FAIL lsb_level got=%0d exp=1", b_level); end
        for (int c = 1; c <= 2 * L1; c++) begin
            if (c > 1) @(negedge clk);
            d = (c <= L1) ? 8'h01 : 8'h80;
            checks++; if (b_tx !== exp_bit(d, (c-1) % L1, 1'b0)) begin failures++; $display("FAIL lsb_tx c=%0d got=%b exp=%b", c, b_tx, exp_bit(d, (c-1) % L1, 1'b0)); end
            checks++; if (b_done !== (((c-1) % L1) == L1 - 1)) begin failures++; $display("FAIL lsb_done c=%0d got=%b", c, b_done); end
            checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL lsb_busy c=%0d got=%b exp=1", c, b_busy); end
        end
        @(negedge clk);
        checks++; if (b_busy !== 1'b0 || b_tx !== 1'b1) begin failures++; $display("FAIL lsb_end busy=%b tx=%b exp 0/1", b_busy, b_tx); end
        b_enable = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        enable = 1'b1; div = 32'd3; stop2 = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_data = 8'h3C;
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (11) @(negedge clk);
        checks++; if (tx !== 1'b0 || level !== 3'd1) begin failures++; $display("FAIL rst_mid_pre tx=%b level=%0d exp 0/1", tx, level); end
        rstn = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_mid_level got=%0d exp=0", level); end
        checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_ready busy=%b rdy=%b exp 0/1", busy, wr_ready); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (level !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_after level=%0d busy=%b exp 0/0", level, busy); end
        div = 32'd0; wr_valid = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int c = 1; c <= L1; c++) begin
            @(negedge clk);
            checks++; if (tx !== exp_bit(8'h3C, c-1, 1'b1)) begin failures++; $display("FAIL rst_new_tx c=%0d got=%b exp=%b", c, tx, exp_bit(8'h3C, c-1, 1'b1)); end
            checks++; if (done !== (c == L1)) begin failures++; $display("FAIL rst_new_done c=%0d got=%b", c, done); end
        end
        @(negedge clk);
    endtask

    task automatic test_enable_stall;
        int flen, eff, n;
        flen = 4 * L1;
        enable = 1'b1; div = 32'd3; stop2 = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int c = 1; c <= flen + 7; c++) begin
            @(negedge clk);
            eff = (c <= 6) ? c : ((c - 7 < 6) ? 6 : c - 7);
            checks++; if (tx !== exp_bit(8'hA5, (eff-1)/4, 1'b1)) begin failures++; $display("FAIL stall_tx c=%0d got=%b exp=%b", c, tx, exp_bit(8'hA5, (eff-1)/4, 1'b1)); end
            checks++; if (done !== (c == flen + 7)) begin failures++; $display("FAIL stall_done c=%0d got=%b", c, done); end
            if (c == 9) begin
                checks++; if (level !== 3'd1) begin failures++; $display("FAIL stall_push_level got=%0d exp=1", level); end
            end
            if (c == 6) enable = 1'b0;
            if (c == 8) begin wr_valid = 1'b1; wr_data = 8'h5A; end
            if (c == 9) wr_valid = 1'b0;
            if (c == 13) enable = 1'b1;
        end
        @(negedge clk);
        checks++; if (tx !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stall_next_start tx=%b busy=%b exp 0/1", tx, busy); end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (busy !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL stall_drain_timeout busy=%b level=%0d exp 0/0", busy, level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop2_latch();
        test_full_backpressure();
        test_lsb_back_to_back();
        test_reset_mid_frame();
        test_enable_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter MSB_FIRST, default 1, serial bit order (1: MSB first, 0: LSB first).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  global advance enable; 0 freezes the transmit engine.
REQ-007 SHALL have port div  input  32  bit period minus one, in clk cycles.
REQ-008 SHALL have port stop2  input  1  1: two stop bits, 0: one stop bit.
REQ-009 SHALL have port wr_valid  input  1  write request into the FIFO.
REQ-010 SHALL have port wr_ready  output  1  FIFO can accept a word.
REQ-011 SHALL have port wr_data  input  DATA_W  word to transmit.
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of each frame.
REQ-015 SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port parity_odd  input  1  parity sense; present only when UART_PARITY_EN is defined.

Function
REQ-017 SHALL push wr_data when wr_valid and wr_ready are both 1; wr_ready = (level != DEPTH), independent of enable.
REQ-018 SHALL make wr_ready depend only on registered level: a push while full is ignored, even in the same cycle as a pop.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-020 SHALL, in IDLE with enable=1 and level>0, pop one word, latch it plus div and stop2, drive tx=0 on the next edge, and enter START.
REQ-021 SHALL hold each bit for exactly div+1 enabled cycles using a down-counter reloaded with the latched div.
REQ-022 SHALL go from START to DATA and send DATA_W bits in MSB_FIRST order, then go to PARITY (when compiled in) or STOP.
REQ-023 SHALL drive tx=1 for one stop bit, or two when stop2 was latched as 1, then pulse done for one cycle and return to IDLE.
REQ-024 SHALL, with a non-empty FIFO at the end of a frame, start the next START bit on the edge after done, with no idle bit.
REQ-025 SHALL make the frame length (1+DATA_W+P+S)*(div+1) cycles, where P is the parity bit count (0/1) and S is the stop bit count (1/2).
REQ-026 SHALL apply changes to div or stop2 during a frame only from the next frame.
REQ-027 SHALL, when enable=0, hold state, counter, shift register and tx unchanged; FIFO pushes still proceed.
REQ-028 SHALL treat div=0 as legal: each bit lasts one cycle.
REQ-029 SHALL update level as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.

Reset
REQ-030 SHALL, on rstn low, immediately set tx=1, busy=0, done=0, level=0 and wr_ready=1, flush the FIFO and enter IDLE, including mid-frame.
REQ-031 SHALL leave FIFO storage contents undefined after reset; they are never observable.

Configuration
REQ-032 SHALL compile a parity bit in when UART_PARITY_EN is defined: PARITY state, one bit, value = XOR of data bits XOR parity_odd.
REQ-033 SHALL, when UART_PARITY_EN is undefined, omit the parity_odd port and the PARITY state, so P=0.

Verification
REQ-034 SHALL cover: DATA_W=8, MSB_FIRST=1, div=3, no parity, push 0xA5 -> tx levels 0,1,0,1,0,0,1,0,1,1, each 4 cycles, done at cycle 40.
REQ-035 SHALL cover: UART_PARITY_EN, parity_odd=0, 0xA5, stop2=1 -> parity bit 0, two stop bits, 48-cycle frame.
REQ-036 SHALL cover: DEPTH=4, enable=0, push 5 words back-to-back -> 4 accepted, wr_ready=0 on the 5th, level=4, tx stays 1.
REQ-037 SHALL cover: MSB_FIRST=0, div=0, push 0x01 then 0x80 -> bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1, with no gap between frames.
REQ-038 SHALL cover: rstn low during the DATA state -> tx=1 and level=0 immediately; after release a new push transmits normally.
REQ-039 SHALL cover: enable low for 7 cycles mid-bit -> the bit is stretched by exactly 7 cycles and frame contents are unchanged.
